// File: rtl/mux_result_scoreboard_if.sv
// Sample bus into the mux result scoreboard and its result/status bus back out.
// The scoreboard uses slave; the driver of samples uses master.
interface mux_result_scoreboard_if #(
  parameter int CW = 16
);
  logic          start;
  logic          in_valid;
  logic [1:0]    sel;
  logic [3:0]    data;
  logic          o_ref;
  logic          o_dut;

  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] mismatch_cnt;
  logic [CW-1:0] sample_idx;
  logic          first_err_valid;
  logic [1:0]    first_err_sel;
  logic [3:0]    first_err_data;
  logic [CW-1:0] first_err_idx;

  modport master (
    output start, in_valid, sel, data, o_ref, o_dut,
    input  busy, done, pass, match_cnt, mismatch_cnt, sample_idx,
           first_err_valid, first_err_sel, first_err_data, first_err_idx
  );

  modport slave (
    input  start, in_valid, sel, data, o_ref, o_dut,
    output busy, done, pass, match_cnt, mismatch_cnt, sample_idx,
           first_err_valid, first_err_sel, first_err_data, first_err_idx
  );
endinterface

// File: rtl/mux_result_scoreboard.sv
// Compares paired 4:1 mux outputs with 4-state equality, keeps saturating
// match/mismatch counts, captures the first failure and issues a verdict.
module mux_result_scoreboard #(
  parameter int NUM_SAMPLES = 2000,
  parameter int CW          = 16
) (
  input logic                    clk,
  input logic                    rst,
  mux_result_scoreboard_if.slave sb
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic          vld;
    logic [1:0]    sel;
    logic [3:0]    data;
    logic [CW-1:0] idx;
  } ferr_t;

  localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_match;
  logic [CW-1:0] r_mism;
  logic [CW-1:0] r_idx;
  ferr_t         r_ferr;
  logic          w_accept;
  logic          w_clear;
  logic          w_same;
  logic          w_last;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Case equality so X/Z on either mux output is compared literally.
  assign w_same   = (sb.o_ref === sb.o_dut);
  assign w_accept = (r_state == S_RUN) && sb.in_valid;
  assign w_clear  = sb.start && (r_state != S_RUN);
  assign w_last   = (r_idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (sb.start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_last) w_next = S_DONE;
      S_DONE:  if (sb.start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sb.busy = (r_state == S_RUN);
    sb.done = (r_state == S_DONE);
    sb.pass = (r_state == S_DONE) && (r_mism == '0);
  end

  // Counters only move on accept, so they are frozen outside RUN.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_match <= '0;
      r_mism  <= '0;
      r_idx   <= '0;
      r_ferr  <= '0;
    end else if (w_accept) begin
      r_idx <= sat_inc(r_idx);
      if (w_same) begin
        r_match <= sat_inc(r_match);
      end else begin
        r_mism <= sat_inc(r_mism);
        if (!r_ferr.vld) r_ferr <= '{vld: 1'b1, sel: sb.sel, data: sb.data, idx: r_idx};
      end
    end
  end

  assign sb.match_cnt       = r_match;
  assign sb.mismatch_cnt    = r_mism;
  assign sb.sample_idx      = r_idx;
  assign sb.first_err_valid = r_ferr.vld;
  assign sb.first_err_sel   = r_ferr.sel;
  assign sb.first_err_data  = r_ferr.data;
  assign sb.first_err_idx   = r_ferr.idx;
endmodule

// File: tb/tb_mux_result_scoreboard.sv
// Randomised bench for mux_result_scoreboard: a queue of accepted samples is
// the reference, and every expected output is derived from that queue.
module tb_mux_result_scoreboard;
  logic clk = 1'b0;
  logic rst0, rst1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mux_result_scoreboard_if #(.CW(16)) if0 ();
  mux_result_scoreboard_if #(.CW(4))  if1 ();

  mux_result_scoreboard #(.NUM_SAMPLES(2000), .CW(16)) u0 (.clk(clk), .rst(rst0), .sb(if0.slave));
  mux_result_scoreboard #(.NUM_SAMPLES(15),   .CW(4))  u1 (.clk(clk), .rst(rst1), .sb(if1.slave));

  typedef struct {
    logic [1:0] s;
    logic [3:0] d;
    logic       m;
  } smp_t;

  smp_t q[$];
  bit   m_run = 1'b0;
  bit   m_done = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int n_match();
    int c = 0;
    foreach (q[i]) if (q[i].m) c++;
    return c;
  endfunction

  function automatic int first_err();
    for (int i = 0; i < q.size(); i++) if (!q[i].m) return i;
    return -1;
  endfunction

  // {busy, done, pass, match, mismatch, idx, ferr_valid, ferr_sel, ferr_data, ferr_idx}
  function automatic logic [73:0] exp_vec(input int mx);
    int nm, ns, nx, fe;
    logic [1:0] fs;
    logic [3:0] fd;
    logic fv, ps;
    nm = sat(n_match(), mx);
    ns = sat(q.size(), mx);
    nx = sat(q.size() - n_match(), mx);
    fe = first_err();
    fv = (fe >= 0);
    fs = 2'b0;
    fd = 4'b0;
    if (fv) begin
      fs = q[fe].s;
      fd = q[fe].d;
    end else begin
      fe = 0;
    end
    ps = m_done && (nx == 0);
    return {m_run, m_done, ps, 16'(nm), 16'(nx), 16'(ns), fv, fs, fd, 16'(fe)};
  endfunction

  function automatic logic [73:0] obs0();
    return {if0.busy, if0.done, if0.pass, if0.match_cnt, if0.mismatch_cnt, if0.sample_idx,
            if0.first_err_valid, if0.first_err_sel, if0.first_err_data, if0.first_err_idx};
  endfunction

  function automatic logic [73:0] obs1();
    return {if1.busy, if1.done, if1.pass, 12'd0, if1.match_cnt, 12'd0, if1.mismatch_cnt,
            12'd0, if1.sample_idx, if1.first_err_valid, if1.first_err_sel, if1.first_err_data,
            12'd0, if1.first_err_idx};
  endfunction

  // Drive one cycle into DUT d (0: u0, 1: u1), advance the model, then step
  // to just after the next rising edge.
  task automatic cycle(input bit d, input bit rs, input bit st, input bit v,
                       input logic [1:0] s, input logic [3:0] dt, input logic r, input logic u);
    int n;
    smp_t e;
    n = d ? 15 : 2000;
    rst0 = !d && rs;
    rst1 = d && rs;
    if0.start = !d && st; if0.in_valid = !d && v; if0.sel = s; if0.data = dt;
    if0.o_ref = r; if0.o_dut = u;
    if1.start = d && st;  if1.in_valid = d && v;  if1.sel = s; if1.data = dt;
    if1.o_ref = r; if1.o_dut = u;
    if (rs) begin
      q.delete(); m_run = 1'b0; m_done = 1'b0;
    end else if (st && !m_run) begin
      q.delete(); m_run = 1'b1; m_done = 1'b0;
    end else if (m_run && v) begin
      e.s = s; e.d = dt; e.m = (r === u);
      q.push_back(e);
      if (q.size() == n) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 1, 0, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    cycle(1, 1, 0, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    total++; if (obs0() !== 74'd0) $display("FAIL reset_u0: got %h expected 0", obs0()); else passed++;
    total++; if (obs1() !== 74'd0) $display("FAIL reset_u1: got %h expected 0", obs1()); else passed++;
  endtask

  task automatic test_all_match();
    logic r;
    // Valid sample in the start cycle must be dropped.
    cycle(0, 0, 1, 1, 2'b1, 4'h5, 1'b0, 1'b1);
    total++; if (if0.busy !== 1'b1 || if0.sample_idx !== 16'd0 || if0.mismatch_cnt !== 16'd0)
      $display("FAIL start_cycle: busy=%b idx=%0d mism=%0d expected 1/0/0", if0.busy, if0.sample_idx, if0.mismatch_cnt);
    else passed++;
    for (int i = 0; i < 2000; i++) begin
      r = 1'($urandom);
      cycle(0, 0, 0, 1, 2'($urandom), 4'($urandom), r, r);
      total++; if (obs0() !== exp_vec(65535))
        $display("FAIL all_match cyc %0d: got %h expected %h", i, obs0(), exp_vec(65535));
      else passed++;
    end
    total++; if (if0.done !== 1'b1 || if0.busy !== 1'b0 || if0.pass !== 1'b1 || if0.match_cnt !== 16'd2000
                 || if0.mismatch_cnt !== 16'd0 || if0.first_err_valid !== 1'b0)
      $display("FAIL all_match_final: done=%b busy=%b pass=%b match=%0d mism=%0d fev=%b expected 1/0/1/2000/0/0",
               if0.done, if0.busy, if0.pass, if0.match_cnt, if0.mismatch_cnt, if0.first_err_valid);
    else passed++;
  endtask

  task automatic test_x_mismatch();
    logic r, u;
    int fe;
    cycle(0, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      r = 1'($urandom);
      u = r;
      if (i == 5 || i == 9) begin r = 1'b1; u = 1'bx; end
      cycle(0, 0, 0, 1, 2'($urandom), 4'($urandom), r, u);
      total++; if (obs0() !== exp_vec(65535))
        $display("FAIL x_mismatch cyc %0d: got %h expected %h", i, obs0(), exp_vec(65535));
      else passed++;
    end
    fe = first_err();
    if (fe >= 0) begin
      total++; if (if0.first_err_idx !== 16'(fe) || if0.first_err_sel !== q[fe].s || if0.first_err_data !== q[fe].d)
        $display("FAIL x_first_err: idx=%0d sel=%0d data=%h expected %0d/%0d/%h",
                 if0.first_err_idx, if0.first_err_sel, if0.first_err_data, fe, q[fe].s, q[fe].d);
      else passed++;
    end
  endtask

  task automatic test_random_mix();
    int cyc = 0;
    cycle(0, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    while (!m_done && cyc < 10000) begin
      cycle(0, 0, ($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));
      total++; if (obs0() !== exp_vec(65535))
        $display("FAIL random_mix cyc %0d: got %h expected %h", cyc, obs0(), exp_vec(65535));
      else passed++;
      cyc++;
    end
    total++; if (!m_done || if0.done !== 1'b1)
      $display("FAIL random_mix_timeout: done=%b after %0d cycles, expected 1", if0.done, cyc);
    else passed++;
  endtask

  task automatic test_xx();
    cycle(0, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      cycle(0, 0, 0, 1, 2'($urandom), 4'($urandom), 1'bx, 1'bx);
      total++; if (obs0() !== exp_vec(65535))
        $display("FAIL xx cyc %0d: got %h expected %h", i, obs0(), exp_vec(65535));
      else passed++;
    end
    total++; if (if0.pass !== 1'b1 || if0.match_cnt !== 16'd2000)
      $display("FAIL xx_final: pass=%b match=%0d expected 1/2000", if0.pass, if0.match_cnt);
    else passed++;
  endtask

  task automatic test_toggle_valid();
    int cyc = 0;
    logic r;
    cycle(0, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    while (!m_done && cyc < 6000) begin
      r = 1'($urandom);
      cycle(0, 0, ($urandom_range(0, 9) == 0), (cyc % 2 == 0), 2'($urandom), 4'($urandom), r, r);
      total++; if (obs0() !== exp_vec(65535))
        $display("FAIL toggle cyc %0d: got %h expected %h", cyc, obs0(), exp_vec(65535));
      else passed++;
      cyc++;
    end
    total++; if (!m_done || if0.done !== 1'b1 || if0.sample_idx !== 16'd2000 || cyc !== 3999)
      $display("FAIL toggle_final: done=%b idx=%0d cycles=%0d expected 1/2000/3999", if0.done, if0.sample_idx, cyc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic r;
    cycle(0, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) cycle(0, 0, 0, 1, 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    total++; if (if0.sample_idx !== 16'd1000)
      $display("FAIL mid_count: idx=%0d expected 1000", if0.sample_idx);
    else passed++;
    // rst and start together: rst wins.
    cycle(0, 1, 1, 1, 2'b11, 4'hf, 1'b1, 1'b0);
    total++; if (obs0() !== 74'd0) $display("FAIL mid_reset: got %h expected 0", obs0()); else passed++;
    cycle(0, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      r = 1'($urandom);
      cycle(0, 0, 0, 1, 2'($urandom), 4'($urandom), r, r);
    end
    total++; if (obs0() !== exp_vec(65535) || if0.pass !== 1'b1)
      $display("FAIL clean_rerun: got %h expected %h", obs0(), exp_vec(65535));
    else passed++;
  endtask

  task automatic test_small();
    cycle(1, 1, 0, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    cycle(1, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cycle(1, 0, 0, 1, 2'($urandom), 4'($urandom), 1'b1, 1'b0);
      total++; if (obs1() !== exp_vec(15))
        $display("FAIL small cyc %0d: got %h expected %h", i, obs1(), exp_vec(15));
      else passed++;
    end
    total++; if (if1.mismatch_cnt !== 4'd15 || if1.done !== 1'b1 || if1.pass !== 1'b0 || if1.first_err_idx !== 4'd0)
      $display("FAIL small_final: mism=%0d done=%b pass=%b fei=%0d expected 15/1/0/0",
               if1.mismatch_cnt, if1.done, if1.pass, if1.first_err_idx);
    else passed++;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 2'b0, 4'b0, 1'b1, 1'b0);
    total++; if (obs1() !== exp_vec(15) || if1.mismatch_cnt !== 4'd15)
      $display("FAIL small_frozen: got %h expected %h", obs1(), exp_vec(15));
    else passed++;
    cycle(1, 0, 1, 0, 2'b0, 4'b0, 1'b0, 1'b0);
    total++; if (obs1() !== {1'b1, 73'd0})
      $display("FAIL small_restart: got %h expected busy only", obs1());
    else passed++;
    for (int i = 0; i < 15; i++) cycle(1, 0, 0, 1, 2'($urandom), 4'($urandom), 1'b0, 1'b0);
    total++; if (obs1() !== exp_vec(15) || if1.pass !== 1'b1 || if1.match_cnt !== 4'd15)
      $display("FAIL small_rerun: got %h expected %h", obs1(), exp_vec(15));
    else passed++;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    test_reset();
    test_all_match();
    test_x_mismatch();
    test_random_mix();
    test_xx();
    test_toggle_valid();
    test_reset_mid();
    test_small();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
